// File: rtl/uart_nand_cmd_bridge.sv
// uart_nand_cmd_bridge: RX byte FIFO + opcode/arg frame parser driving the NAND master port; define UART_ECHO_EN to echo every popped byte before parsing
module uart_nand_cmd_bridge #(
    parameter int         FIFO_DEPTH   = 16,
    parameter int         ACT_CYCLES   = 2,
    parameter int         BUSY_TIMEOUT = 4096,
    parameter logic [2:0] LED_RESET    = 3'b010
) (
    input  logic       hw_clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] nand_cmd,
    output logic       nand_activate,
    output logic [7:0] nand_din,
    input  logic [7:0] nand_dout,
    input  logic       nand_busy,
    output logic [2:0] rgb,
    output logic       rx_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, OPC, ARG, ACT, WAIT, RESP, ECHO} state_t;
    state_t state_q, state_d;
`ifdef UART_ECHO_EN
    state_t ret_q, ret_d;
`endif
    logic [7:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0] opc_q, opc_d, resp_q, resp_d, cmd_q, cmd_d, din_q, din_d, head;
    logic [2:0] rgb_q, rgb_d;
    logic [31:0] cnt_q, cnt_d;
    logic ovf_q, ovf_d, empty, full, pop, push;

    assign head          = mem_q[rd_q[AW-1:0]];
    assign empty         = wr_q == rd_q;
    assign full          = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign tx_valid      = state_q == RESP || state_q == ECHO;
    assign tx_data       = resp_q;
    assign nand_activate = state_q == ACT;
    assign nand_cmd      = cmd_q;
    assign nand_din      = din_q;
    assign rgb           = rgb_q;
    assign rx_overflow   = ovf_q;

    // FIFO pointers: a write on full is only accepted when the same cycle also pops
    always_comb begin
        push  = rx_valid && (!full || pop);
        wr_d  = wr_q + (AW+1)'(push);
        rd_d  = rd_q + (AW+1)'(pop);
        ovf_d = ovf_q | (rx_valid & full & !pop);
    end

    // Frame parser: one frame in flight, side effects applied when the argument is popped
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        resp_d  = resp_q;
        cmd_d   = cmd_q;
        din_d   = din_q;
        rgb_d   = rgb_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
`ifdef UART_ECHO_EN
        ret_d   = ret_q;
`endif
        case (state_q)
            IDLE: if (!empty) begin
                pop   = 1'b1;
                opc_d = head;
`ifdef UART_ECHO_EN
                resp_d  = head;
                ret_d   = OPC;
                state_d = ECHO;
`else
                state_d = OPC;
`endif
            end
            OPC: begin
                state_d = (opc_q == "L" || opc_q == "C" || opc_q == "W") ? ARG : RESP;
                resp_d  = (opc_q == "D") ? nand_dout : 8'h3F;
            end
            ARG: if (!empty) begin
                pop    = 1'b1;
                rgb_d  = (opc_q == "L") ? head[2:0] : rgb_q;
                din_d  = (opc_q == "W") ? head : din_q;
                cmd_d  = (opc_q == "C") ? head : cmd_q;
                cnt_d  = '0;
`ifdef UART_ECHO_EN
                resp_d  = head;
                ret_d   = (opc_q == "C") ? ACT : RESP;
                state_d = ECHO;
`else
                resp_d  = 8'h4B;
                state_d = (opc_q == "C") ? ACT : RESP;
`endif
            end
            ACT: begin
                cnt_d   = (cnt_q == 32'(ACT_CYCLES - 1)) ? '0 : cnt_q + 32'd1;
                state_d = (cnt_q == 32'(ACT_CYCLES - 1)) ? WAIT : ACT;
            end
            WAIT: if (!nand_busy) begin
                resp_d  = 8'h4B;
                state_d = RESP;
            end else if (BUSY_TIMEOUT != 0 && cnt_q == 32'(BUSY_TIMEOUT - 1)) begin
                resp_d  = 8'h54;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            RESP: state_d = tx_ready ? IDLE : RESP;
`ifdef UART_ECHO_EN
            ECHO: if (tx_ready) begin
                resp_d  = 8'h4B;
                state_d = ret_q;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage: no reset needed, emptiness is tracked by the pointers
    always_ff @(posedge hw_clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= rx_data;
    end

    // State and output registers; reset aborts any frame and empties the FIFO
    always_ff @(posedge hw_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            opc_q   <= '0;
            resp_q  <= '0;
            cmd_q   <= '0;
            din_q   <= '0;
            rgb_q   <= LED_RESET;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef UART_ECHO_EN
            ret_q   <= IDLE;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            opc_q   <= opc_d;
            resp_q  <= resp_d;
            cmd_q   <= cmd_d;
            din_q   <= din_d;
            rgb_q   <= rgb_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef UART_ECHO_EN
            ret_q   <= ret_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_nand_cmd_bridge.sv
// tb_uart_nand_cmd_bridge: scoreboard bench with a frame-level reference model and a NAND busy responder
module tb_uart_nand_cmd_bridge;
    localparam int TO = 64;
    localparam logic [7:0] K = 8'h4B, T = 8'h54, Q = 8'h3F;

    logic hw_clk = 0, reset = 1, rx_valid = 0, tx_ready = 0, nand_busy = 0;
    logic [7:0] rx_data = 0, nand_dout = 0;
    logic tx_valid, nand_activate, rx_overflow;
    logic [7:0] tx_data, nand_cmd, nand_din;
    logic [2:0] rgb;

    int checks = 0, fails = 0;
    logic [7:0] exp_q[$];
    logic hold_ready = 0, stall = 0, prev_act = 0;
    logic [7:0] held = 0, exp_cmd = 0;
    int busy_len = 0, rem = 0, alen = 0, acts = 0, exp_acts = 0;
    logic [2:0] m_rgb = 3'b010;
    logic [7:0] m_din = 0, m_cmd = 0;

    uart_nand_cmd_bridge #(.BUSY_TIMEOUT(TO)) dut (
        .hw_clk(hw_clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .nand_cmd(nand_cmd), .nand_activate(nand_activate), .nand_din(nand_din),
        .nand_dout(nand_dout), .nand_busy(nand_busy), .rgb(rgb), .rx_overflow(rx_overflow)
    );

    always #5 hw_clk = ~hw_clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // tx monitor: drives tx_ready, pops the scoreboard on each handshake
    initial forever begin
        @(negedge hw_clk);
        tx_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
        if (stall && tx_valid && !reset) chk("tx_data_stable", tx_data, held);
        if (tx_valid && tx_ready && !reset) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
            end else begin
                checks--;
                chk("tx_byte", tx_data, exp_q.pop_front());
            end
        end
        stall = tx_valid && !tx_ready;
        held  = tx_data;
    end

    // NAND model: busy held high for busy_len cycles after activate drops
    initial forever begin
        @(negedge hw_clk);
        if (reset) begin
            rem = 0; nand_busy = 0; prev_act = 0;
        end else begin
            if (prev_act && !nand_activate) rem = busy_len;
            nand_busy = rem > 0;
            if (rem > 0) rem--;
            prev_act = nand_activate;
        end
    end

    // activate monitor: pulse length and command value
    initial forever begin
        @(negedge hw_clk);
        if (reset) alen = 0;
        else if (nand_activate) begin
            if (alen == 0) chk("nand_cmd_at_act", nand_cmd, exp_cmd);
            alen++;
        end else if (alen != 0) begin
            chk("act_len", alen, 2);
            acts++;
            alen = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(logic [7:0] b);
        @(negedge hw_clk); rx_valid = 1; rx_data = b;
        @(negedge hw_clk); rx_valid = 0;
    endtask

    task automatic do_frame(logic [7:0] op, logic [7:0] arg, int blen);
        case (op)
            "L": begin m_rgb = arg[2:0]; exp_q.push_back(K); end
            "W": begin m_din = arg; exp_q.push_back(K); end
            "C": begin
                m_cmd = arg; exp_cmd = arg; exp_acts++; busy_len = blen;
                exp_q.push_back(blen >= TO ? T : K);
            end
            "D": exp_q.push_back(nand_dout);
            default: exp_q.push_back(Q);
        endcase
        send_byte(op);
        if (op inside {"L", "W", "C"}) send_byte(arg);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge hw_clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; fails++;
            $display("FAIL reply_timeout: %0d replies pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge hw_clk);
    endtask

    task automatic check_model();
        chk("rgb", rgb, m_rgb);
        chk("nand_din", nand_din, m_din);
        chk("nand_cmd", nand_cmd, m_cmd);
    endtask

    task automatic check_reset();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_activate", nand_activate, 0);
        chk("rst_overflow", rx_overflow, 0);
        check_model();
    endtask

    task automatic wait_act(logic lvl);
        int n = 0;
        while (nand_activate !== lvl && n < 40) begin @(negedge hw_clk); n++; end
        chk("act_seen", nand_activate, lvl);
    endtask

    initial begin
        logic [7:0] op;
        int n, blen;
        repeat (3) @(negedge hw_clk);
        check_reset();
        reset = 0;
        @(negedge hw_clk);
        do_frame("L", 8'h05, 0); wait_idle();
        chk("rgb_L05", rgb, 3'b101);
        chk("no_activate", acts, 0);
        do_frame("C", 8'h90, 10); wait_idle();
        chk("cmd_90", nand_cmd, 8'h90);
        do_frame("C", 8'hFF, 1000);
        wait_act(1); wait_act(0);
        n = 0;
        while (!tx_valid && n < 200) begin @(negedge hw_clk); n++; end
        chk("timeout_cycles", n, TO);
        wait_idle();
        do_frame("W", 8'hA5, 0);
        nand_dout = 8'h3C;
        do_frame("D", 0, 0);
        wait_idle();
        chk("din_A5", nand_din, 8'hA5);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: op = "L";
                1: op = "W";
                2: op = "C";
                3: op = "D";
                default: do op = 8'($urandom_range(0, 255)); while (op inside {"L", "W", "C", "D"});
            endcase
            if (op == "D") nand_dout = 8'($urandom);
            blen = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 20);
            do_frame(op, 8'($urandom), blen);
            wait_idle();
            check_model();
        end
        chk("ovf_before", rx_overflow, 0);
        hold_ready = 1;
        repeat (2) @(negedge hw_clk);
        for (int i = 0; i < 10; i++) begin
            if (i < 9) begin m_rgb = 3'(i + 3); exp_q.push_back(K); end
            send_byte("L");
            send_byte(8'(i + 3));
        end
        chk("ovf_after", rx_overflow, 1);
        hold_ready = 0;
        wait_idle();
        repeat (20) @(negedge hw_clk);
        chk("rgb_after_ovf", rgb, 3'b011);
        do_frame("Z", 0, 0); wait_idle();
        do_frame("C", 8'h42, 1000);
        wait_act(1); wait_act(0);
        repeat (5) @(negedge hw_clk);
        reset = 1;
        exp_q.delete();
        m_rgb = 3'b010; m_din = 0; m_cmd = 0; busy_len = 0;
        repeat (2) @(negedge hw_clk);
        check_reset();
        reset = 0;
        repeat (50) @(negedge hw_clk);
        check_reset();
        chk("activations", acts, exp_acts);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
